// File: rtl/spi_sub_frame_if.sv
// spi_sub_frame_if: SPI pins plus the received-frame and response-word handshake of spi_sub_frame.
// Bit vectors declared [0:N] carry the first serial bit at index 0.
interface spi_sub_frame_if;
  logic         cs_n;
  logic         sclk;
  logic         mosi;
  logic         miso;
  logic [1:0]   rx_mode;    // rx_mode[1] is frame bit 0
  logic [0:255] rx_data;
  logic         rx_valid;
  logic         frame_err;
  logic [0:127] tx_data;
  logic         tx_load;

  modport master (
    output cs_n, sclk, mosi, tx_data, tx_load,
    input  miso, rx_mode, rx_data, rx_valid, frame_err
  );

  modport slave (
    input  cs_n, sclk, mosi, tx_data, tx_load,
    output miso, rx_mode, rx_data, rx_valid, frame_err
  );
endinterface

// File: rtl/spi_sub_frame.sv
// spi_sub_frame: SPI mode-0 subordinate that receives one mode-tagged payload per chip-select
// window and returns a 128-bit response word on miso.
// Build option: define SPI_SUB_OVERRUN_CHK_EN to reject frames carrying more bits than the
// length implied by their mode; when undefined, surplus bits are dropped and the frame accepted.
module spi_sub_frame #(
  parameter int unsigned SYNC_STAGES = 2  // legal range 2..3
) (
  input logic            clk,
  input logic            rst,
  spi_sub_frame_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StRecv, StCheck} state_e;

  localparam int unsigned RxBits = 258;
  localparam logic [8:0]  CntMax = 9'd258;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] cs_sync_q, sclk_sync_q, mosi_sync_q;
  logic                   cs_prev_q, sclk_prev_q;
  logic                   cs_fall_q, cs_rise_q;
  logic                   cs_s, sclk_s, mosi_s, sclk_rise, sclk_fall;

  logic [0:RxBits-1] rx_sr_q;
  logic [8:0]        cnt_q;
  logic [1:0]        mode_q;
  logic [8:0]        len;
  logic [0:255]      payload;
  logic              mode_legal, at_len, frame_ok, frame_start, shift_en, check;

  logic [1:0]   rx_mode_q;
  logic [0:255] rx_data_q;
  logic         rx_valid_q, frame_err_q;

  logic [0:127] tx_word_q, tx_sr_q, pend_q;
  logic         pend_vld_q;

  assign cs_s   = cs_sync_q[SYNC_STAGES-1];
  assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

  // sclk edges act immediately to leave miso settling margin; cs edges take one extra flop.
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign sclk_fall = ~sclk_s & sclk_prev_q;

  // Synchronizers and edge detect. Chains clear to 0 so a select already low at reset release
  // is never mistaken for a fresh fall; the frame is skipped until cs_n has been seen high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs_sync_q   <= '0;
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_prev_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      cs_fall_q   <= 1'b0;
      cs_rise_q   <= 1'b0;
    end else begin
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
      cs_prev_q   <= cs_s;
      sclk_prev_q <= sclk_s;
      cs_fall_q   <= cs_prev_q & ~cs_s;
      cs_rise_q   <= ~cs_prev_q & cs_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a fall seen in StCheck starts the next frame straight away.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (cs_fall_q) state_d = StRecv;
      StRecv:  if (cs_rise_q) state_d = StCheck;
      StCheck: state_d = cs_fall_q ? StRecv : StIdle;
      default: state_d = StIdle;
    endcase
  end

  assign frame_start = cs_fall_q && (state_q != StRecv);
  assign shift_en    = sclk_rise && (state_q == StRecv);
  assign check       = (state_q == StCheck);

  // Expected length and payload extraction; the shift register stops at the frame length, so
  // the payload always ends at the last register bit.
  always_comb begin
    len     = CntMax;
    payload = '0;
    case (mode_q)
      2'b00: begin
        len     = 9'd130;
        payload = {rx_sr_q[130:257], 128'b0};
      end
      2'b01: begin
        len     = 9'd194;
        payload = {rx_sr_q[66:257], 64'b0};
      end
      default: begin
        len     = 9'd258;
        payload = rx_sr_q[2:257];
      end
    endcase
  end

  assign mode_legal = (mode_q != 2'b11);
  // Below two bits the counter is under any legal length, so a half-decoded mode is harmless.
  assign at_len     = mode_legal && (cnt_q >= len);

`ifdef SPI_SUB_OVERRUN_CHK_EN
  logic ovf_q;

  // Sticky flag: a bit arrived after the frame was already full (covers the saturated 258 case).
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (frame_start) begin
      ovf_q <= 1'b0;
    end else if (shift_en && at_len) begin
      ovf_q <= 1'b1;
    end
  end

  assign frame_ok = mode_legal && (cnt_q == len) && !ovf_q;
`else
  assign frame_ok = mode_legal && (cnt_q >= len);
`endif

  // Receive shift register, saturating bit counter and mode capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sr_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else if (frame_start) begin
      rx_sr_q <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else if (shift_en) begin
      if (cnt_q != CntMax) cnt_q <= cnt_q + 9'd1;
      if (cnt_q == 9'd0) mode_q[1] <= mosi_s;
      if (cnt_q == 9'd1) mode_q[0] <= mosi_s;
      if (!at_len) rx_sr_q <= {rx_sr_q[1:RxBits-1], mosi_s};
    end
  end

  // Frame verdict: exactly one pulse per frame; held data changes only on acceptance.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      rx_mode_q   <= '0;
      rx_data_q   <= '0;
    end else begin
      rx_valid_q  <= check && frame_ok;
      frame_err_q <= check && !frame_ok;
      if (check && frame_ok) begin
        rx_mode_q <= mode_q;
        rx_data_q <= payload;
      end
    end
  end

  // Response path: direct load outside a frame, deferred load during one, reload at frame start.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_word_q  <= '0;
      tx_sr_q    <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
    end else begin
      if (bus.tx_load && (state_q != StRecv)) begin
        tx_word_q  <= bus.tx_data;
        tx_sr_q    <= bus.tx_data;
        pend_vld_q <= 1'b0;
      end else if (frame_start) begin
        if (pend_vld_q) begin
          tx_word_q  <= pend_q;
          tx_sr_q    <= pend_q;
          pend_vld_q <= 1'b0;
        end else begin
          tx_sr_q <= tx_word_q;
        end
      end else if ((state_q == StRecv) && sclk_fall) begin
        // Zero fill makes miso read 0 once all 128 bits are out.
        tx_sr_q <= {tx_sr_q[1:127], 1'b0};
      end
      if (bus.tx_load && (state_q == StRecv)) begin
        pend_q     <= bus.tx_data;
        pend_vld_q <= 1'b1;
      end
    end
  end

  assign bus.miso      = (state_q == StRecv) ? tx_sr_q[0] : 1'b0;
  assign bus.rx_mode   = rx_mode_q;
  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_sub_frame.sv
// tb_spi_sub_frame: drives SPI frames into spi_sub_frame and scores verdict pulses and miso bits
// against a frame-level reference model.
module tb_spi_sub_frame;
  localparam int unsigned S = 2;
  localparam int H = 4;  // sclk half period in clk cycles

  typedef struct {
    bit           ok;
    logic [1:0]   mode;
    logic [0:255] data;
    int unsigned  due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int unsigned cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[$];
  bit   miso_q[$];
  bit   frame_bits[$];

  // Reference model state
  logic [1:0]   m_mode;
  logic [0:255] m_data;
  logic [0:127] m_word, m_pend;
  bit           m_pend_vld;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  spi_sub_frame_if bus ();
  spi_sub_frame #(.SYNC_STAGES(S)) dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [0:255] ramp(input int nbytes);
    logic [0:255] r;
    r = '0;
    for (int k = 0; k < nbytes; k++) r[8*k +: 8] = 8'(k);
    return r;
  endfunction

  task automatic build(input logic [1:0] m, input logic [0:255] pay, input int n);
    frame_bits.delete();
    for (int i = 0; i < n; i++) begin
      bit b;
      if (i == 0) b = m[1];
      else if (i == 1) b = m[0];
      else if (i - 2 < 256) b = pay[i-2];
      else b = 1'($urandom_range(0, 1));
      frame_bits.push_back(b);
    end
  endtask

  // Verdict from the frame's own rules: length by mode, payload = bits after the mode field.
  task automatic model_push();
    exp_t e;
    int n, l;
    bit ok;
    logic [1:0] m;
    n  = frame_bits.size();
    ok = 1'b0;
    if (n >= 2) begin
      m  = {frame_bits[0], frame_bits[1]};
      l  = 130 + 64 * int'(m);
`ifdef SPI_SUB_OVERRUN_CHK_EN
      ok = (m != 2'b11) && (n == l);
`else
      ok = (m != 2'b11) && (n >= l);
`endif
      if (ok) begin
        m_mode = m;
        m_data = '0;
        for (int j = 0; j < l - 2; j++) m_data[j] = frame_bits[2+j];
      end
    end
    e.ok   = ok;
    e.mode = m_mode;
    e.data = m_data;
    e.due  = cyc + S + 3;
    exp_q.push_back(e);
  endtask

  task automatic pulse_load(input logic [0:127] w);
    bus.tx_data = w;
    bus.tx_load = 1'b1;
    @(negedge clk);
    bus.tx_load = 1'b0;
  endtask

  task automatic idle_load(input logic [0:127] w);
    pulse_load(w);
    m_word     = w;
    m_pend_vld = 1'b0;
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  // sclk toggles with cs_n high must be ignored and miso must stay 0.
  task automatic wiggle(input int k);
    for (int i = 0; i < k; i++) begin
      miso_q.push_back(1'b0);
      bus.sclk = 1'b1;
      gap(2);
      bus.sclk = 1'b0;
      gap(2);
    end
  endtask

  task automatic send_frame(input int load_at, input logic [0:127] w1, input logic [0:127] w2,
                            input bit two_loads, input int rst_at);
    logic [0:127] word;
    bit aborted;
    aborted = 1'b0;
    if (m_pend_vld) begin
      m_word     = m_pend;
      m_pend_vld = 1'b0;
    end
    word = m_word;
    bus.cs_n = 1'b0;
    gap(2 * H);
    for (int i = 0; i < frame_bits.size(); i++) begin
      bus.mosi = frame_bits[i];
      gap(H);
      miso_q.push_back((!aborted && i < 128) ? word[i] : 1'b0);
      bus.sclk = 1'b1;
      gap(H);
      bus.sclk = 1'b0;
      if (i == load_at) begin
        pulse_load(w1);
        if (two_loads) pulse_load(w2);
        m_pend     = two_loads ? w2 : w1;
        m_pend_vld = 1'b1;
      end
      if (i == rst_at) begin
        rst = 1'b1;
        gap(2);
        rst = 1'b0;
        m_mode = '0;
        m_data = '0;
        m_word = '0;
        m_pend = '0;
        m_pend_vld = 1'b0;
        aborted = 1'b1;
        @(negedge clk);
        check("rst_rx_mode", bus.rx_mode, 2'b00);
        check("rst_rx_data", bus.rx_data, 256'd0);
        check("rst_miso", bus.miso, 1'b0);
        check("rst_pulses", {bus.rx_valid, bus.frame_err}, 2'b00);
      end
    end
    gap(H);
    bus.cs_n = 1'b1;
    if (!aborted) model_push();
  endtask

  // Verdict monitor: pops one expectation per pulse; also flags expectations left overdue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && (bus.rx_valid || bus.frame_err)) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL pulse_unexpected: got valid=%0b err=%0b, required no pulse",
                   bus.rx_valid, bus.frame_err);
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", {bus.rx_valid, bus.frame_err}, e.ok ? 2'b10 : 2'b01);
          check("pulse_cycle", cyc, e.due);
          check("rx_mode", bus.rx_mode, e.mode);
          check("rx_data", bus.rx_data, e.data);
        end
      end
      if (exp_q.size() > 0 && cyc > exp_q[0].due) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pulse_missing: got none by cycle %0d, required at cycle %0d",
                 cyc, exp_q[0].due);
        void'(exp_q.pop_front());
      end
    end
  end

  // miso monitor: the main samples miso on each sclk rise.
  initial begin
    forever begin
      @(posedge bus.sclk);
      if (miso_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL miso_unexpected: got %0b with no expectation queued", bus.miso);
      end else begin
        check("miso", bus.miso, miso_q.pop_front());
      end
    end
  end

  initial begin
    repeat (99000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, required finish within 99000 cycles");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:255] pay;
    logic [0:127] wa, wb, wc;
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.tx_load = 1'b0;
    bus.tx_data = '0;
    m_mode = '0;
    m_data = '0;
    m_word = '0;
    m_pend = '0;
    m_pend_vld = 1'b0;
    gap(5);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rx_valid", bus.rx_valid, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_rx_mode", bus.rx_mode, 2'b00);
    check("reset_rx_data", bus.rx_data, 256'd0);
    check("reset_miso", bus.miso, 1'b0);

    // Known response word over an all-zero mode-00 frame
    idle_load(128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    build(2'b00, '0, 130);
    send_frame(-1, '0, '0, 1'b0, -1);
    gap(20);
    wiggle(3);

    build(2'b00, ramp(16), 130);
    send_frame(-1, '0, '0, 1'b0, -1);
    gap(20);
    build(2'b01, ramp(24), 194);
    send_frame(-1, '0, '0, 1'b0, -1);
    gap(20);
    build(2'b10, ramp(32), 258);
    send_frame(-1, '0, '0, 1'b0, -1);
    gap(20);

    // Truncated frame and illegal mode: both rejected, held data unchanged
    build(2'b00, ramp(16), 100);
    send_frame(-1, '0, '0, 1'b0, -1);
    gap(20);
    build(2'b11, ramp(32), 258);
    send_frame(-1, '0, '0, 1'b0, -1);
    gap(20);

    // Loads during a frame defer to the next one; the last of two wins
    wa = 128'h0123456789abcdeffedcba9876543210;
    wb = 128'hdeadbeef00112233445566778899aabb;
    wc = 128'hcafef00d5a5a5a5aa5a5a5a512345678;
    idle_load(wa);
    build(2'b00, ramp(16), 130);
    send_frame(50, wc, wb, 1'b1, -1);
    gap(20);
    build(2'b00, '0, 130);
    send_frame(-1, '0, '0, 1'b0, -1);
    gap(20);

    // Reset mid-frame; the remainder of that select window is ignored
    build(2'b01, ramp(24), 194);
    send_frame(-1, '0, '0, 1'b0, 60);
    gap(20);

    // One surplus bit, then a back-to-back frame with cs_n high a single cycle
    build(2'b00, ramp(16), 131);
    send_frame(-1, '0, '0, 1'b0, -1);
    gap(1);
    build(2'b01, ramp(24), 194);
    send_frame(-1, '0, '0, 1'b0, -1);
    gap(20);

    for (int r = 0; r < 14; r++) begin
      logic [1:0] m;
      int l, n, sel, load_at, g;
      m = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      l = (m == 2'b11) ? 258 : 130 + 64 * int'(m);
      sel = $urandom_range(0, 5);
      if (sel == 0) n = l - $urandom_range(1, 20);
      else if (sel == 1) n = l + $urandom_range(1, 3);
      else n = l;
      for (int k = 0; k < 8; k++) pay[32*k +: 32] = $urandom;
      build(m, pay, n);
      load_at = ($urandom_range(0, 2) == 0) ? $urandom_range(4, n - 4) : -1;
      wa = {$urandom, $urandom, $urandom, $urandom};
      wb = {$urandom, $urandom, $urandom, $urandom};
      send_frame(load_at, wa, wb, 1'($urandom_range(0, 1)), -1);
      g = ($urandom_range(0, 3) == 0) ? 1 : $urandom_range(2, 14);
      gap(g);
      if (g >= S + 4 && $urandom_range(0, 2) == 0) idle_load({$urandom, $urandom, $urandom, $urandom});
    end

    gap(20);
    for (int t = 0; t < 200 && (exp_q.size() > 0 || miso_q.size() > 0); t++) @(negedge clk);
    if (exp_q.size() > 0 || miso_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d verdicts and %0d miso bits outstanding, required 0",
               exp_q.size(), miso_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
